// File: rtl/dmg_timer_unit.sv
// DMG timer/divider at FF04-FF07: DIV, TIMA, TMA, TAC with falling-edge tick
// detection and the one-M-cycle delayed TMA reload that raises IRQ_TIMER.
module dmg_timer_unit #(
  parameter int OVF_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  output logic        IRQ_TIMER
);

  localparam int CW = $clog2(OVF_DELAY + 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_OVF_WAIT
  } state_t;

  state_t          r_state;
  logic [15:0]     r_div_cnt;
  logic [7:0]      r_tima;
  logic [7:0]      r_tma;
  logic [2:0]      r_tac;
  logic            r_tick_prev;
  logic [CW-1:0]   r_ovf_cnt;
  logic            r_irq;

  state_t          w_state_nxt;
  logic [7:0]      w_tima_nxt;
  logic [CW-1:0]   w_ovf_nxt;
  logic            w_irq_nxt;
  logic            w_sel_bit;
  logic            w_tick_now;
  logic            w_fall;
  logic            w_wr_div;
  logic            w_wr_tima;
  logic            w_wr_tma;
  logic            w_wr_tac;
  logic [7:0]      w_tma_eff;
  logic            w_unused_rd;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign w_unused_rd = RD;

  assign w_wr_div  = WR && (ADDR == 16'hFF04);
  assign w_wr_tima = WR && (ADDR == 16'hFF05);
  assign w_wr_tma  = WR && (ADDR == 16'hFF06);
  assign w_wr_tac  = WR && (ADDR == 16'hFF07);

  // A TMA write landing on the reload edge must feed the reload itself.
  assign w_tma_eff = w_wr_tma ? MMIO_DATA_out : r_tma;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_sel_bit = 1'b0;
    unique case (r_tac[1:0])
      2'b00: w_sel_bit = r_div_cnt[9];
      2'b01: w_sel_bit = r_div_cnt[3];
      2'b10: w_sel_bit = r_div_cnt[5];
      2'b11: w_sel_bit = r_div_cnt[7];
    endcase
  end

  // DIV clears and TAC edits change these immediately, so they can create real edges.
  assign w_tick_now = r_tac[2] & w_sel_bit;
  assign w_fall     = r_tick_prev & ~w_tick_now;

  always_comb begin
    w_state_nxt = r_state;
    w_tima_nxt  = r_tima;
    w_ovf_nxt   = r_ovf_cnt;
    w_irq_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_tima) begin
          w_tima_nxt = MMIO_DATA_out;
        end else if (w_fall) begin
          if (r_tima == 8'hFF) begin
            w_tima_nxt  = 8'h00;
            w_ovf_nxt   = CW'(1);
            w_state_nxt = S_OVF_WAIT;
          end else begin
            w_tima_nxt = r_tima + 8'd1;
          end
        end
      end
      S_OVF_WAIT: begin
        if (r_ovf_cnt == CW'(OVF_DELAY)) begin
          w_tima_nxt  = w_tma_eff;
          w_irq_nxt   = 1'b1;
          w_ovf_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_wr_tima) begin
          w_tima_nxt  = MMIO_DATA_out;
          w_ovf_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_ovf_nxt = r_ovf_cnt + CW'(1);
          if (w_fall) begin
            w_tima_nxt = r_tima + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and uses non-blocking assignments like every other state update.
    if (rst) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= 16'h0000;
      r_tima      <= 8'h00;
      r_tma       <= 8'h00;
      r_tac       <= 3'b000;
      r_tick_prev <= 1'b0;
      r_ovf_cnt   <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_cnt   <= w_wr_div ? 16'h0000 : r_div_cnt + 16'd1;
      r_tima      <= w_tima_nxt;
      r_tick_prev <= w_tick_now;
      r_ovf_cnt   <= w_ovf_nxt;
      r_irq       <= w_irq_nxt;
      if (w_wr_tma) begin
        r_tma <= MMIO_DATA_out;
      end
      if (w_wr_tac) begin
        r_tac <= MMIO_DATA_out[2:0];
      end
    end
  end

  always_comb begin
    MMIO_DATA_in = 8'hFF;
    unique case (ADDR)
      16'hFF04: MMIO_DATA_in = r_div_cnt[15:8];
      16'hFF05: MMIO_DATA_in = r_tima;
      16'hFF06: MMIO_DATA_in = r_tma;
      16'hFF07: MMIO_DATA_in = {5'b11111, r_tac};
      default:  MMIO_DATA_in = 8'hFF;
    endcase
  end

  assign IRQ_TIMER = r_irq;

endmodule

// File: tb/tb_dmg_timer_unit.sv
// Scoreboard bench for dmg_timer_unit: expected register/IRQ values are queued
// as stimulus is driven and popped when the DUT is sampled on the negedge.
module tb_dmg_timer_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ADDR = 16'h0000;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  logic [7:0]  MMIO_DATA_out = 8'h00;
  logic [7:0]  MMIO_DATA_in;
  logic        IRQ_TIMER;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] sb_q[$];
  logic       irq_q[$];

  dmg_timer_unit #(.OVF_DELAY(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ADDR         (ADDR),
    .WR           (WR),
    .RD           (RD),
    .MMIO_DATA_out(MMIO_DATA_out),
    .MMIO_DATA_in (MMIO_DATA_in),
    .IRQ_TIMER    (IRQ_TIMER)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // All tasks are entered and left at a negedge; "t" below counts posedges since reset.
  task automatic reset_dut();
    rst = 1'b1;
    WR  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    ADDR = a;
    MMIO_DATA_out = d;
    WR = 1'b1;
    @(negedge clk);
    WR = 1'b0;
    ADDR = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    ADDR = a;
    RD = 1'b1;
    #1;
    d = MMIO_DATA_in;
    RD = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] addrs[6] = '{16'hFF04, 16'hFF05, 16'hFF06, 16'hFF07, 16'hFF08, 16'hFF03};
    logic [7:0] d, e;
    logic ei;
    reset_dut();
    sb_q.push_back(8'h00); sb_q.push_back(8'h00); sb_q.push_back(8'h00);
    sb_q.push_back(8'hF8); sb_q.push_back(8'hFF); sb_q.push_back(8'hFF);
    irq_q.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], d);
      e = sb_q.pop_front();
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL reset_read %h: got %h expected %h", addrs[i], d, e);
      end
    end
    ei = irq_q.pop_front();
    n_run++;
    if (IRQ_TIMER !== ei) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected %b", IRQ_TIMER, ei);
    end
    sb_q.push_back(8'h0A);
    tick(2560);
    bus_read(16'hFF04, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL div_2560: got %h expected %h", d, e);
    end
  endtask

  task automatic test_count();
    logic [7:0] d, e;
    int waits[3] = '{15, 1, 240};
    reset_dut();
    bus_write(16'hFF07, 8'h05);
    sb_q.push_back(8'h00); sb_q.push_back(8'h01); sb_q.push_back(8'h10);
    for (int i = 0; i < 3; i++) begin
      tick(waits[i]);
      bus_read(16'hFF05, d);
      e = sb_q.pop_front();
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL count step %0d: got %h expected %h", i, d, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d, e;
    logic ei;
    logic [7:0] exp_tima[8] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hAB, 8'hAB};
    logic       exp_irq[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    bus_write(16'hFF06, 8'hAB);
    bus_write(16'hFF05, 8'hFF);
    bus_write(16'hFF07, 8'h05);
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(exp_tima[k]);
      irq_q.push_back(exp_irq[k]);
    end
    tick(13);
    for (int k = 0; k < 8; k++) begin
      bus_read(16'hFF05, d);
      e  = sb_q.pop_front();
      ei = irq_q.pop_front();
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL ovf_tima t=%0d: got %h expected %h", 16 + k, d, e);
      end
      n_run++;
      if (IRQ_TIMER !== ei) begin
        n_fail++;
        $display("FAIL ovf_irq t=%0d: got %b expected %b", 16 + k, IRQ_TIMER, ei);
      end
      tick(1);
    end
  endtask

  task automatic test_cancel();
    logic [7:0] d, e;
    logic ei;
    reset_dut();
    bus_write(16'hFF06, 8'h77);
    bus_write(16'hFF05, 8'hFF);
    bus_write(16'hFF07, 8'h05);
    sb_q.push_back(8'h00);
    tick(15);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL cancel_pending: got %h expected %h", d, e);
    end
    bus_write(16'hFF05, 8'h42);
    for (int k = 0; k < 7; k++) begin
      sb_q.push_back(8'h42);
      irq_q.push_back(1'b0);
    end
    for (int k = 0; k < 7; k++) begin
      bus_read(16'hFF05, d);
      e  = sb_q.pop_front();
      ei = irq_q.pop_front();
      n_run++;
      if (d !== e || IRQ_TIMER !== ei) begin
        n_fail++;
        $display("FAIL cancel t=%0d: got tima=%h irq=%b expected tima=%h irq=%b",
                 19 + k, d, IRQ_TIMER, e, ei);
      end
      tick(1);
    end
  endtask

  task automatic test_reload_collisions();
    logic [7:0] d, e;
    logic ei;
    for (int pass = 0; pass < 2; pass++) begin
      reset_dut();
      bus_write(16'hFF06, 8'hAB);
      bus_write(16'hFF05, 8'hFF);
      bus_write(16'hFF07, 8'h05);
      tick(17);
      if (pass == 0) begin
        bus_write(16'hFF05, 8'h55);
        sb_q.push_back(8'hAB);
      end else begin
        bus_write(16'hFF06, 8'hCD);
        sb_q.push_back(8'hCD);
      end
      irq_q.push_back(1'b1);
      bus_read(16'hFF05, d);
      e  = sb_q.pop_front();
      ei = irq_q.pop_front();
      n_run++;
      if (d !== e || IRQ_TIMER !== ei) begin
        n_fail++;
        $display("FAIL reload_collision pass %0d: got tima=%h irq=%b expected tima=%h irq=%b",
                 pass, d, IRQ_TIMER, e, ei);
      end
      irq_q.push_back(1'b0);
      tick(1);
      ei = irq_q.pop_front();
      n_run++;
      if (IRQ_TIMER !== ei) begin
        n_fail++;
        $display("FAIL reload_irq_width pass %0d: got %b expected %b", pass, IRQ_TIMER, ei);
      end
    end
  endtask

  task automatic test_write_vs_tick();
    logic [7:0] d, e;
    reset_dut();
    bus_write(16'hFF07, 8'h05);
    bus_write(16'hFF05, 8'h10);
    tick(14);
    bus_write(16'hFF05, 8'h30);
    sb_q.push_back(8'h30); sb_q.push_back(8'h30); sb_q.push_back(8'h31);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL write_vs_tick t=17: got %h expected %h", d, e);
    end
    tick(15);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL write_vs_tick t=32: got %h expected %h", d, e);
    end
    tick(1);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL write_vs_tick t=33: got %h expected %h", d, e);
    end
  endtask

  task automatic test_div_write();
    logic [7:0] d, e;
    // div_cnt = 0200: selected bit 9 set, clearing DIV is a falling edge.
    reset_dut();
    bus_write(16'hFF07, 8'h04);
    tick(511);
    sb_q.push_back(8'h02);
    bus_read(16'hFF04, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL div_pre: got %h expected %h", d, e);
    end
    bus_write(16'hFF04, 8'h5A);
    sb_q.push_back(8'h00); sb_q.push_back(8'h01); sb_q.push_back(8'h00); sb_q.push_back(8'h01);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL divwr_tima_t513: got %h expected %h", d, e);
    end
    tick(1);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL divwr_tima_t514: got %h expected %h", d, e);
    end
    tick(254);
    bus_read(16'hFF04, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL divwr_clear_255: got %h expected %h", d, e);
    end
    tick(1);
    bus_read(16'hFF04, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL divwr_clear_256: got %h expected %h", d, e);
    end
    // div_cnt = 0100: selected bit 9 clear, no edge.
    reset_dut();
    bus_write(16'hFF07, 8'h04);
    tick(255);
    bus_write(16'hFF04, 8'h00);
    tick(2);
    sb_q.push_back(8'h00);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL divwr_no_edge: got %h expected %h", d, e);
    end
  endtask

  task automatic test_tac_change();
    logic [7:0] d, e;
    logic [7:0] new_tac[2] = '{8'h01, 8'h06};
    for (int pass = 0; pass < 2; pass++) begin
      reset_dut();
      bus_write(16'hFF07, 8'h05);
      tick(8);
      bus_write(16'hFF07, new_tac[pass]);
      sb_q.push_back(8'h00); sb_q.push_back(8'h01); sb_q.push_back(8'h01);
      bus_read(16'hFF05, d);
      e = sb_q.pop_front();
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL tac_change%0d t=10: got %h expected %h", pass, d, e);
      end
      tick(1);
      bus_read(16'hFF05, d);
      e = sb_q.pop_front();
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL tac_change%0d t=11: got %h expected %h", pass, d, e);
      end
      tick(20);
      bus_read(16'hFF05, d);
      e = sb_q.pop_front();
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL tac_change%0d t=31: got %h expected %h", pass, d, e);
      end
    end
    sb_q.push_back(8'hFE);
    bus_read(16'hFF07, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL tac_readback: got %h expected %h", d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    logic ei;
    logic [7:0] exp_tima[3] = '{8'h01, 8'hAB, 8'hAB};
    logic       exp_irq[3]  = '{1'b0, 1'b1, 1'b0};
    reset_dut();
    bus_write(16'hFF06, 8'hAB);
    bus_write(16'hFF05, 8'hFD);
    bus_write(16'hFF07, 8'h05);
    tick(46);
    sb_q.push_back(8'h00);
    bus_read(16'hFF05, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL b2b_overflow: got %h expected %h", d, e);
    end
    // Select bit 5 (currently 1), then disable: a real edge inside OVF_WAIT.
    bus_write(16'hFF07, 8'h06);
    bus_write(16'hFF07, 8'h02);
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(exp_tima[k]);
      irq_q.push_back(exp_irq[k]);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1);
      bus_read(16'hFF05, d);
      e  = sb_q.pop_front();
      ei = irq_q.pop_front();
      n_run++;
      if (d !== e || IRQ_TIMER !== ei) begin
        n_fail++;
        $display("FAIL b2b t=%0d: got tima=%h irq=%b expected tima=%h irq=%b",
                 52 + k, d, IRQ_TIMER, e, ei);
      end
    end
  endtask

  task automatic test_reset_mid_ovf();
    logic [7:0] d, e;
    logic ei;
    reset_dut();
    bus_write(16'hFF06, 8'hAB);
    bus_write(16'hFF05, 8'hFF);
    bus_write(16'hFF07, 8'h05);
    tick(15);
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(8'h00);
      irq_q.push_back(1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      bus_read(16'hFF05, d);
      e  = sb_q.pop_front();
      ei = irq_q.pop_front();
      n_run++;
      if (d !== e || IRQ_TIMER !== ei) begin
        n_fail++;
        $display("FAIL reset_mid_ovf k=%0d: got tima=%h irq=%b expected tima=%h irq=%b",
                 k, d, IRQ_TIMER, e, ei);
      end
      tick(1);
    end
    sb_q.push_back(8'h00);
    bus_read(16'hFF06, d);
    e = sb_q.pop_front();
    n_run++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL reset_mid_ovf_tma: got %h expected %h", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_cancel();
    test_reload_collisions();
    test_write_vs_tick();
    test_div_write();
    test_tac_change();
    test_back_to_back();
    test_reset_mid_ovf();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmg_timer_unit.md
Name: dmg_timer_unit

Overview:
DMG timer/divider peripheral mapped at FF04-FF07. Sits beside the PPU on the CPU MMIO bus inside the LR35902 top-level and feeds the timer interrupt request into the interrupt-flag register FF0F bit 2. It implements DIV, TIMA, TMA and TAC, including falling-edge tick detection and the delayed TMA reload with its interrupt.

Parameters:
OVF_DELAY, 4, clk cycles between TIMA overflow (TIMA=00) and the TMA reload/IRQ (one M-cycle).

Ports:
clk  in  1  4.194304 MHz system clock; one clk = one T-cycle
rst  in  1  synchronous reset, active-high
ADDR  in  16  CPU address
WR  in  1  CPU write strobe, high active, sampled at posedge clk
RD  in  1  CPU read strobe, high active; reads have no side effects
MMIO_DATA_out  in  8  write data from CPU
MMIO_DATA_in  out  8  read data to CPU, combinational from ADDR
IRQ_TIMER  out  1  one-clk pulse requesting FF0F[2]

Behaviour:
- Reset (rst=1 at posedge): div_cnt=0000, TIMA=00, TMA=00, TAC=000, tick_prev=0, state=IDLE, ovf_cnt=0, IRQ_TIMER=0.
- div_cnt is a 16-bit internal counter. It increments by 1 every clk and wraps FFFF->0000.
- Register reads (combinational):
  - FF04 = div_cnt[15:8]
  - FF05 = TIMA
  - FF06 = TMA
  - FF07 = {5'b11111, TAC}
  - any other ADDR = FF
- Writes (ADDR match and WR=1, take effect at posedge):
  - FF04: any data clears div_cnt to 0000.
  - FF05: TIMA=data.
  - FF06: TMA=data.
  - FF07: TAC=data[2:0].
- Tick source bit selected by TAC[1:0]: 00->div_cnt[9] (4096 Hz), 01->div_cnt[3] (262144 Hz), 10->div_cnt[5] (65536 Hz), 11->div_cnt[7] (16384 Hz).
- tick_now = TAC[2] & selected bit, evaluated on register values after the current posedge update. tick_prev <= tick_now every clk.
- Falling edge = tick_prev & ~tick_now. The following are real edges and increment TIMA: a DIV write while the selected bit=1, clearing TAC[2] while the bit=1, and a TAC select change that moves from a 1 bit to a 0 bit.
- On a falling edge, TIMA increments at the next posedge.
- FSM:
  - IDLE: an increment with TIMA=FF sets TIMA=00, ovf_cnt=1, state=OVF_WAIT.
  - OVF_WAIT: ovf_cnt increments every clk. When ovf_cnt==OVF_DELAY: TIMA<=TMA, IRQ_TIMER<=1 for exactly one clk, state=IDLE.
  - Overflow posedge at P: reload and IRQ_TIMER high at posedge P+4, IRQ_TIMER low again at P+5. During OVF_WAIT, TIMA reads 00.
  - A CPU write to FF05 during OVF_WAIT, before the reload posedge, cancels the reload and IRQ: TIMA=written value, state=IDLE.
  - A tick increment during OVF_WAIT increments TIMA; the reload still occurs.
- Simultaneous events:
  - CPU write to FF05 and a tick increment in the same cycle: the write wins, no increment.
  - FF05 write on the reload posedge: ignored, TMA is loaded and the IRQ fires.
  - FF06 write on the reload posedge: the new TMA value is loaded into TIMA.
  - FF04 write and div_cnt increment in the same cycle: div_cnt=0000.
- Reset mid-operation returns every state to reset values on that posedge; any pending reload/IRQ is dropped.
- IRQ_TIMER is registered with no combinational path from inputs. The top ORs it into FF0F[2].

Test Plan:
- Reset then read: FF04=00, FF05=00, FF06=00, FF07=F8; IRQ_TIMER=0. After 256*10 clks, FF04=0A.
- TAC=05 (enable, div_cnt[3]), TIMA=00 -> TIMA increments once every 16 clks, reaching 10 after 256 clks.
- TMA=AB, TIMA=FF, TAC=05 -> TIMA=00 for 4 clks after overflow, then AB; IRQ_TIMER high for exactly 1 clk, 4 clks after overflow.
- Overflow pending, write TIMA=42 two clks after overflow -> TIMA=42, no IRQ_TIMER pulse, no TMA reload.
- TAC=04, div_cnt[9]=1 (div_cnt=0200), write FF04 -> TIMA increments by 1 and div_cnt=0000. Same sequence with div_cnt=0100 -> no increment.
- TAC=05 then write TAC=01 while div_cnt[3]=1 -> TIMA increments by 1. Assert rst during OVF_WAIT -> TIMA=00, no IRQ_TIMER pulse.
